// File: rtl/pi_step_calc_pkg.sv
// Shared widths, FSM encoding and the saturating clamp used by the PI step calculator.
package pi_step_calc_pkg;
  localparam int ADC_WID         = 18;
  localparam int CONSTS_WHOLE    = 21;
  localparam int CONSTS_FRAC     = 43;
  localparam int CYCLE_COUNT_WID = 18;
  localparam int MUL_B_WID       = 20;

  localparam int CONSTS_WID = CONSTS_WHOLE + CONSTS_FRAC;
  localparam int E_WID      = ADC_WID + 1;
  localparam int DE_WID     = ADC_WID + 2;
  localparam int PROD_WID   = CONSTS_WID + MUL_B_WID;
  localparam int SUM_WID    = CONSTS_WID + 2;

  typedef enum logic [2:0] {
    S_IDLE, S_ERR, S_MUL_P, S_MUL_IC, S_MUL_IE, S_SUM, S_DONE
  } state_t;

  typedef struct packed {
    logic                  sat;
    logic [CONSTS_WID-1:0] val;
  } clamp_t;

  // Clamp a wide signed value into the CONSTS_WID range and flag whether it clipped.
  function automatic clamp_t sat_c(input logic signed [PROD_WID-1:0] x);
    logic signed [PROD_WID-1:0] hi, lo;
    clamp_t r;
    hi = PROD_WID'({1'b0, {(CONSTS_WID-1){1'b1}}});
    lo = ~hi;
    r.sat = (x > hi) || (x < lo);
    if (x > hi)      r.val = hi[CONSTS_WID-1:0];
    else if (x < lo) r.val = lo[CONSTS_WID-1:0];
    else             r.val = x[CONSTS_WID-1:0];
    return r;
  endfunction
endpackage

// File: rtl/pi_step_calc_seq_mul.sv
// Radix-2 shift-add signed multiplier: one bit of B per cycle, last step subtracts for B's sign bit.
module seq_mul_signed
  import pi_step_calc_pkg::*;
#(
  parameter int A_WID = CONSTS_WID,
  parameter int B_WID = MUL_B_WID
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            clr,
  input  logic                            start,
  input  logic signed [A_WID-1:0]         a,
  input  logic signed [B_WID-1:0]         b,
  output logic                            busy,
  output logic                            done,
  output logic signed [A_WID+B_WID-1:0]   p
);
  localparam int P_WID   = A_WID + B_WID;
  localparam int CNT_WID = $clog2(B_WID);

  logic signed [P_WID-1:0] a_sh;
  logic [B_WID-1:0]        b_sh;
  logic [CNT_WID-1:0]      cnt;
  logic                    last;

  assign last = (cnt == CNT_WID'(B_WID - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
      cnt  <= '0;
      a_sh <= '0;
      b_sh <= '0;
      p    <= '0;
    end else if (clr) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else if (start) begin
      a_sh <= P_WID'(a);
      b_sh <= b;
      p    <= '0;
      cnt  <= '0;
      busy <= 1'b1;
      done <= 1'b0;
    end else if (busy) begin
      // Two's-complement weight of the top B bit is negative, hence the subtract.
      if (b_sh[0]) p <= last ? p - a_sh : p + a_sh;
      a_sh <= a_sh <<< 1;
      b_sh <= b_sh >> 1;
      cnt  <= cnt + CNT_WID'(1);
      if (last) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end else begin
      done <= 1'b0;
    end
  end
endmodule

// File: rtl/pi_step_calc.sv
// One PI-controller update: error, P term, I term via a single shared sequential multiplier.
module pi_step_calc
  import pi_step_calc_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       arm,
  output logic                       finished,
  input  logic [ADC_WID-1:0]         setpt,
  input  logic [ADC_WID-1:0]         measured,
  input  logic [CONSTS_WID-1:0]      cl_P,
  input  logic [CONSTS_WID-1:0]      cl_I,
  input  logic [CYCLE_COUNT_WID-1:0] cycles,
  input  logic [E_WID-1:0]           e_prev,
  input  logic [CONSTS_WID-1:0]      adjval_prev,
  output logic [E_WID-1:0]           e_cur,
  output logic [CONSTS_WID-1:0]      adj_val,
  output logic                       saturated
);
  state_t state, state_n;

  logic signed [ADC_WID-1:0]    setpt_q, meas_q;
  logic signed [CONSTS_WID-1:0] p_q, i_q, adjp_q, tp_q, tic_q, ti_q;
  logic [CYCLE_COUNT_WID-1:0]   cyc_q;
  logic signed [E_WID-1:0]      eprev_q, e_q, e_c;
  logic signed [DE_WID-1:0]     de_q, de_c;
  logic                         sat_q, running, in_mul;
  logic                         mul_clr, mul_start, mul_busy, mul_done;
  logic signed [CONSTS_WID-1:0] mul_a;
  logic signed [MUL_B_WID-1:0]  mul_b;
  logic signed [PROD_WID-1:0]   mul_p;
  logic signed [SUM_WID-1:0]    sum;
  clamp_t                       prod_c, sum_c;

  assign in_mul    = (state inside {S_MUL_P, S_MUL_IC, S_MUL_IE});
  assign running   = in_mul || (state inside {S_ERR, S_SUM});
  assign mul_clr   = running && !arm;
  // Kick the multiplier on the first cycle of each multiply state.
  assign mul_start = in_mul && !mul_busy && !mul_done;

  assign e_c    = E_WID'(setpt_q) - E_WID'(meas_q);
  assign de_c   = DE_WID'(e_c) - DE_WID'(eprev_q);
  assign prod_c = sat_c(mul_p);
  assign sum    = SUM_WID'(adjp_q) + SUM_WID'(tp_q) + SUM_WID'(ti_q);
  assign sum_c  = sat_c(PROD_WID'(sum));

  always_comb begin
    mul_a = p_q;
    mul_b = MUL_B_WID'(de_q);
    case (state)
      S_MUL_IC: begin
        mul_a = i_q;
        mul_b = MUL_B_WID'({1'b0, cyc_q});
      end
      S_MUL_IE: begin
        mul_a = tic_q;
        mul_b = MUL_B_WID'(e_q);
      end
      default: ;
    endcase
  end

  seq_mul_signed #(.A_WID(CONSTS_WID), .B_WID(MUL_B_WID)) u_mul (
    .clk   (clk),
    .rst   (rst),
    .clr   (mul_clr),
    .start (mul_start),
    .a     (mul_a),
    .b     (mul_b),
    .busy  (mul_busy),
    .done  (mul_done),
    .p     (mul_p)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:   if (arm) state_n = S_ERR;
      S_ERR:    state_n = S_MUL_P;
      S_MUL_P:  if (mul_done) state_n = S_MUL_IC;
      S_MUL_IC: if (mul_done) state_n = S_MUL_IE;
      S_MUL_IE: if (mul_done) state_n = S_SUM;
      S_SUM:    state_n = S_DONE;
      S_DONE:   if (!arm) state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
    if (running && !arm) state_n = S_IDLE;
  end

  // Operand and intermediate registers carry no reset; they are always written before use.
  always_ff @(posedge clk) begin
    case (state)
      S_IDLE: if (arm) begin
        setpt_q <= setpt;
        meas_q  <= measured;
        p_q     <= cl_P;
        i_q     <= cl_I;
        cyc_q   <= cycles;
        eprev_q <= e_prev;
        adjp_q  <= adjval_prev;
      end
      S_ERR: begin
        e_q  <= e_c;
        de_q <= de_c;
      end
      S_MUL_P:  if (mul_done) tp_q  <= prod_c.val;
      S_MUL_IC: if (mul_done) tic_q <= prod_c.val;
      S_MUL_IE: if (mul_done) ti_q  <= prod_c.val;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      finished  <= 1'b0;
      e_cur     <= '0;
      adj_val   <= '0;
      saturated <= 1'b0;
      sat_q     <= 1'b0;
    end else begin
      finished <= (state == S_DONE) && arm;
      if (state == S_IDLE && arm) sat_q <= 1'b0;
      else if (in_mul && mul_done) sat_q <= sat_q | prod_c.sat;
      if (state == S_SUM && arm) begin
        e_cur     <= e_q;
        adj_val   <= sum_c.val;
        saturated <= sat_q | sum_c.sat;
      end
    end
  end
endmodule

// File: tb/tb_pi_step_calc.sv
// Scoreboard bench for pi_step_calc: expected results queued at arm time, checked on finished.
module tb_pi_step_calc;
  import pi_step_calc_pkg::*;

  typedef struct {
    logic [E_WID-1:0]      e;
    logic [CONSTS_WID-1:0] adj;
    logic                  sat;
  } exp_t;

  logic                       clk = 1'b0;
  logic                       rst, arm, finished, saturated;
  logic [ADC_WID-1:0]         setpt, measured;
  logic [CONSTS_WID-1:0]      cl_P, cl_I, adjval_prev, adj_val;
  logic [CYCLE_COUNT_WID-1:0] cycles;
  logic [E_WID-1:0]           e_prev, e_cur;

  exp_t sb[$];
  exp_t last_out;
  int   errors = 0;
  int   checks = 0;

  pi_step_calc dut (
    .clk(clk), .rst(rst), .arm(arm), .finished(finished),
    .setpt(setpt), .measured(measured), .cl_P(cl_P), .cl_I(cl_I),
    .cycles(cycles), .e_prev(e_prev), .adjval_prev(adjval_prev),
    .e_cur(e_cur), .adj_val(adj_val), .saturated(saturated)
  );

  always #5 clk = ~clk;

  function automatic logic [64:0] clamp(input logic signed [127:0] x);
    logic signed [127:0] hi, lo;
    hi = (128'sd1 <<< 63) - 128'sd1;
    lo = -(128'sd1 <<< 63);
    if (x > hi) return {1'b1, hi[63:0]};
    if (x < lo) return {1'b1, lo[63:0]};
    return {1'b0, x[63:0]};
  endfunction

  function automatic exp_t model(input logic signed [ADC_WID-1:0] sp, ms,
                                 input logic signed [CONSTS_WID-1:0] pp, ii,
                                 input logic [CYCLE_COUNT_WID-1:0] cy,
                                 input logic signed [E_WID-1:0] ep,
                                 input logic signed [CONSTS_WID-1:0] ap);
    logic signed [127:0] e, de, tp, tic, ti, w;
    logic [64:0]         c;
    logic signed [63:0]  v;
    exp_t r;
    r.sat = 1'b0;
    e  = sp - ms;
    de = e - ep;
    w  = pp;
    c  = clamp(w * de);  r.sat |= c[64]; v = c[63:0]; tp = v;
    w  = ii;
    tic = cy;
    c  = clamp(w * tic); r.sat |= c[64]; v = c[63:0]; tic = v;
    c  = clamp(tic * e); r.sat |= c[64]; v = c[63:0]; ti = v;
    w  = ap;
    c  = clamp(w + tp + ti); r.sat |= c[64];
    r.adj = c[63:0];
    r.e   = e[E_WID-1:0];
    return r;
  endfunction

  // Called #1 after a clock edge; arm is sampled on the next edge.
  task automatic drive(input logic [ADC_WID-1:0] sp, ms, input logic [CONSTS_WID-1:0] pp, ii,
                       input logic [CYCLE_COUNT_WID-1:0] cy, input logic [E_WID-1:0] ep,
                       input logic [CONSTS_WID-1:0] ap, input bit push, input exp_t x);
    setpt = sp; measured = ms; cl_P = pp; cl_I = ii;
    cycles = cy; e_prev = ep; adjval_prev = ap;
    arm = 1'b1;
    if (push) sb.push_back(x);
  endtask

  task automatic collect(input string name, input int exp_lat);
    int   n;
    exp_t x;
    n = -1;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      if (finished === 1'b1) begin
        n = k;
        break;
      end
    end
    checks++;
    if (n < 0) begin
      errors++;
      $display("FAIL %s_timeout: finished low after 200 edges, required high", name);
    end
    if (exp_lat >= 0 && n >= 0) begin
      checks++;
      if (n !== exp_lat) begin
        errors++;
        $display("FAIL %s_latency: got %0d edges, expected %0d", name, n, exp_lat);
      end
    end
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s_scoreboard: no expected entry queued", name);
    end else begin
      x = sb.pop_front();
      checks++;
      if (e_cur !== x.e) begin
        errors++;
        $display("FAIL %s_e_cur: got %0d, expected %0d", name, $signed(e_cur), $signed(x.e));
      end
      checks++;
      if (adj_val !== x.adj) begin
        errors++;
        $display("FAIL %s_adj_val: got %h, expected %h", name, adj_val, x.adj);
      end
      checks++;
      if (saturated !== x.sat) begin
        errors++;
        $display("FAIL %s_saturated: got %b, expected %b", name, saturated, x.sat);
      end
      last_out = x;
    end
    arm = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (finished !== 1'b0) begin
      errors++;
      $display("FAIL %s_release: finished=%b after arm low, expected 0", name, finished);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; arm = 1'b0;
    setpt = '0; measured = '0; cl_P = '0; cl_I = '0;
    cycles = '0; e_prev = '0; adjval_prev = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (finished !== 1'b0)  begin errors++; $display("FAIL reset_finished: got %b, expected 0", finished); end
    checks++; if (e_cur !== '0)       begin errors++; $display("FAIL reset_e_cur: got %h, expected 0", e_cur); end
    checks++; if (adj_val !== '0)     begin errors++; $display("FAIL reset_adj_val: got %h, expected 0", adj_val); end
    checks++; if (saturated !== 1'b0) begin errors++; $display("FAIL reset_saturated: got %b, expected 0", saturated); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_p_only();
    drive(ADC_WID'(1000), ADC_WID'(900), 64'd1 << 43, '0, CYCLE_COUNT_WID'(7), '0, '0,
          1'b1, '{e: E_WID'(100), adj: 64'd100 << 43, sat: 1'b0});
    collect("p_only", 69);
  endtask

  task automatic test_i_only();
    drive('0, ADC_WID'(-4), '0, 64'd1 << 42, CYCLE_COUNT_WID'(10), '0, '0,
          1'b1, '{e: E_WID'(4), adj: 64'd20 << 43, sat: 1'b0});
    collect("i_only", 69);
  endtask

  task automatic test_clamp();
    drive(ADC_WID'(131071), ADC_WID'(-131072), 64'h7FFF_FFFF_FFFF_FFFF, '0, '0,
          E_WID'(-262144), '0,
          1'b1, '{e: E_WID'(262143), adj: 64'h7FFF_FFFF_FFFF_FFFF, sat: 1'b1});
    collect("clamp", 69);
  endtask

  task automatic test_neg_extreme();
    drive(ADC_WID'(-131072), ADC_WID'(131071), 64'hFFFF_F800_0000_0000, '0, '0, '0, '0,
          1'b1, '{e: E_WID'(-262143), adj: 64'd262143 << 43, sat: 1'b0});
    collect("neg_extreme", 69);
  endtask

  task automatic test_zero_terms();
    drive(ADC_WID'(5000), ADC_WID'(-300), '0, '0, CYCLE_COUNT_WID'(12345), E_WID'(77),
          64'h0123_4567_89AB_CDEF,
          1'b1, '{e: E_WID'(5300), adj: 64'h0123_4567_89AB_CDEF, sat: 1'b0});
    collect("zero_gains", 69);
    drive(ADC_WID'(-20), ADC_WID'(20), '0, 64'h0000_7000_0000_0000, '0, '0,
          64'hFEDC_0000_0000_0001,
          1'b1, '{e: E_WID'(-40), adj: 64'hFEDC_0000_0000_0001, sat: 1'b0});
    collect("zero_cycles", 69);
  endtask

  // Most negative A operand: -2^63 * 1 stays exact, -2^63 * -1 must clamp.
  task automatic test_min_operand();
    drive(ADC_WID'(1), '0, 64'h8000_0000_0000_0000, '0, '0, '0, '0,
          1'b1, '{e: E_WID'(1), adj: 64'h8000_0000_0000_0000, sat: 1'b0});
    collect("min_p", 69);
    drive('0, ADC_WID'(1), '0, 64'h8000_0000_0000_0000, CYCLE_COUNT_WID'(1), '0, '0,
          1'b1, '{e: E_WID'(-1), adj: 64'h7FFF_FFFF_FFFF_FFFF, sat: 1'b1});
    collect("min_i", 69);
  endtask

  task automatic test_abort();
    exp_t keep;
    int   hits;
    keep = last_out;
    drive(ADC_WID'(1000), ADC_WID'(900), 64'd1 << 43, '0, CYCLE_COUNT_WID'(7), '0, '0, 1'b0, keep);
    repeat (30) @(posedge clk);
    #1 arm = 1'b0;
    hits = 0;
    repeat (100) begin
      @(posedge clk); #1;
      if (finished !== 1'b0) hits++;
    end
    checks++; if (hits != 0)         begin errors++; $display("FAIL abort_finished: high on %0d edges, expected 0", hits); end
    checks++; if (e_cur !== keep.e)    begin errors++; $display("FAIL abort_e_cur: got %h, expected %h", e_cur, keep.e); end
    checks++; if (adj_val !== keep.adj) begin errors++; $display("FAIL abort_adj_val: got %h, expected %h", adj_val, keep.adj); end
    checks++; if (saturated !== keep.sat) begin errors++; $display("FAIL abort_saturated: got %b, expected %b", saturated, keep.sat); end
    drive(ADC_WID'(1000), ADC_WID'(900), 64'd1 << 43, '0, CYCLE_COUNT_WID'(7), '0, '0,
          1'b1, '{e: E_WID'(100), adj: 64'd100 << 43, sat: 1'b0});
    collect("abort_rearm", 69);
  endtask

  task automatic test_rst_mid();
    exp_t dummy;
    dummy = last_out;
    drive('0, ADC_WID'(-4), '0, 64'd1 << 42, CYCLE_COUNT_WID'(10), '0, '0, 1'b0, dummy);
    repeat (40) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checks++; if (finished !== 1'b0)  begin errors++; $display("FAIL rstmid_finished: got %b, expected 0", finished); end
    checks++; if (e_cur !== '0)       begin errors++; $display("FAIL rstmid_e_cur: got %h, expected 0", e_cur); end
    checks++; if (adj_val !== '0)     begin errors++; $display("FAIL rstmid_adj_val: got %h, expected 0", adj_val); end
    checks++; if (saturated !== 1'b0) begin errors++; $display("FAIL rstmid_saturated: got %b, expected 0", saturated); end
    arm = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    drive('0, ADC_WID'(-4), '0, 64'd1 << 42, CYCLE_COUNT_WID'(10), '0, '0,
          1'b1, '{e: E_WID'(4), adj: 64'd20 << 43, sat: 1'b0});
    collect("rst_rearm", 69);
  endtask

  task automatic test_random(input string tag, input int n);
    logic signed [CONSTS_WID-1:0] pp, ii, ap;
    logic [ADC_WID-1:0]           sp, ms;
    logic [E_WID-1:0]             ep;
    logic [CYCLE_COUNT_WID-1:0]   cy;
    exp_t x;
    for (int t = 0; t < n; t++) begin
      sp = ADC_WID'($urandom());
      ms = ADC_WID'($urandom());
      ep = E_WID'($urandom());
      cy = CYCLE_COUNT_WID'($urandom_range(0, 262143));
      pp = {$urandom(), $urandom()};
      pp = pp >>> $urandom_range(20, 63);
      ii = {$urandom(), $urandom()};
      ii = ii >>> $urandom_range(30, 63);
      ap = {$urandom(), $urandom()};
      ap = ap >>> $urandom_range(0, 63);
      x = model(sp, ms, pp, ii, cy, ep, ap);
      drive(sp, ms, pp, ii, cy, ep, ap, 1'b1, x);
      collect($sformatf("%s%0d", tag, t), 69);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_p_only();
    test_i_only();
    test_clamp();
    test_neg_extreme();
    test_zero_terms();
    test_min_operand();
    test_abort();
    test_rst_mid();
    test_random("rand", 6);
    test_random("b2b", 3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
